// File: rtl/spi_stream_tx.sv
// SPI slave transmitter: drains a BYTES-wide stream word (tkeep byte enables) and a priority
// meta byte onto spi_miso. SCLK/CS are synchronised into clk; mode and byte order are parameters.
module spi_stream_tx #(
    parameter int BYTES     = 4,
    parameter int CPOL      = 0,
    parameter int CPHA      = 0,
    parameter int LSB_FIRST = 1,
    parameter int SYNC      = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               spi_cs_n,
    input  logic               spi_sclk,
    output logic               spi_miso,
    input  logic               s_tvalid,
    input  logic [8*BYTES-1:0] s_tdata,
    input  logic [BYTES-1:0]   s_tkeep,
    output logic               s_tready,
    input  logic               meta_valid,
    input  logic [7:0]         meta_data,
    output logic               meta_ready,
    output logic               busy,
    output logic               byte_done,
    output logic               underrun
);
    localparam int PW          = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam bit LAUNCH_FALL = (CPOL == CPHA);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
    state_t state;

    logic [SYNC-1:0]    cs_sync, sclk_sync;
    logic               cs_s, sclk_s, cs_d, sclk_d;
    logic               rise, fall, lch, smp, cs_fall;

    logic [8*BYTES-1:0] wreg;
    logic [BYTES-1:0]   wkeep, rem;
    logic               wfull;
    logic [PW-1:0]      p, bsel;
    logic [7:0]         mreg;
    logic               mfull;
    logic [7:0]         sh_buf;
    logic               sh_loaded;
    logic [2:0]         c;
    logic               acc_w, acc_m, ld_ok, ld_meta, ld_word, cur_keep, last_smp;
    logic [7:0]         cur_byte, ld_byte;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sync   <= '1;
            sclk_sync <= (CPOL != 0) ? '1 : '0;
            cs_d      <= 1'b1;
            sclk_d    <= (CPOL != 0);
        end else begin
            cs_sync   <= {cs_sync[SYNC-2:0], spi_cs_n};
            sclk_sync <= {sclk_sync[SYNC-2:0], spi_sclk};
            cs_d      <= cs_s;
            sclk_d    <= sclk_s;
        end
    end

    assign cs_s    = cs_sync[SYNC-1];
    assign sclk_s  = sclk_sync[SYNC-1];
    assign rise    = sclk_s & ~sclk_d;
    assign fall    = ~sclk_s & sclk_d;
    assign lch     = ~cs_s & (LAUNCH_FALL ? fall : rise);
    assign smp     = ~cs_s & (LAUNCH_FALL ? rise : fall);
    assign cs_fall = cs_d & ~cs_s;

    always_comb begin
        bsel     = (LSB_FIRST != 0) ? p : PW'(BYTES - 1) - p;
        cur_byte = wreg[{bsel, 3'b000} +: 8];
        cur_keep = wkeep[bsel];
        rem      = wkeep & ~(BYTES'(1) << bsel);
        acc_w    = s_tvalid & s_tready;
        acc_m    = meta_valid & meta_ready;
        // Only load on a byte boundary of the master's frame so a late byte is never sent torn.
        ld_ok    = (c == 3'd0) & ~smp;
        ld_meta  = (state == LOAD) & mfull & ld_ok;
        ld_word  = (state == LOAD) & ~mfull & wfull & cur_keep & ld_ok;
        ld_byte  = mfull ? mreg : cur_byte;
        last_smp = smp & (c == 3'd7);
    end

    assign busy = wfull | mfull | sh_loaded;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wreg       <= '0;
            wkeep      <= '0;
            wfull      <= 1'b0;
            p          <= '0;
            mreg       <= '0;
            mfull      <= 1'b0;
            sh_buf     <= '0;
            sh_loaded  <= 1'b0;
            c          <= '0;
            spi_miso   <= 1'b1;
            s_tready   <= 1'b0;
            meta_ready <= 1'b0;
            byte_done  <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            byte_done <= last_smp & sh_loaded;
            underrun  <= last_smp & ~sh_loaded;

            if (cs_s)     c <= '0;
            else if (smp) c <= c + 3'd1;

            // CPHA=0 needs bit 7 on the line before the first edge, hence the load/CS updates.
            if (cs_s)                                   spi_miso <= 1'b1;
            else if (CPHA == 0 && (ld_meta || ld_word)) spi_miso <= ld_byte[7];
            else if (CPHA == 0 && cs_fall)              spi_miso <= ~sh_loaded | sh_buf[7];
            else if (lch)                               spi_miso <= ~sh_loaded | sh_buf[3'd7 - c];

            if (ld_meta || ld_word) begin
                sh_buf    <= ld_byte;
                sh_loaded <= 1'b1;
            end else if (last_smp) begin
                sh_loaded <= 1'b0;
            end

            case (state)
                IDLE: if (wfull | mfull | acc_w | acc_m) state <= LOAD;
                LOAD: begin
                    if (ld_meta) begin
                        mfull      <= 1'b0;
                        meta_ready <= 1'b1;
                        state      <= SHIFT;
                    end else if (!mfull && wfull && (ld_word || !cur_keep)) begin
                        wkeep <= rem;
                        if (rem == '0) begin
                            wfull    <= 1'b0;
                            s_tready <= 1'b1;
                            p        <= '0;
                        end else begin
                            p <= p + PW'(1);
                        end
                        if (ld_word) state <= SHIFT;
                    end else if (!mfull && !wfull && !acc_w && !acc_m) begin
                        state <= IDLE;
                    end
                end
                SHIFT: if (last_smp) state <= (wfull | mfull | acc_w | acc_m) ? LOAD : IDLE;
                default: state <= IDLE;
            endcase

            if (acc_w) begin
                wreg     <= s_tdata;
                wkeep    <= s_tkeep;
                wfull    <= 1'b1;
                s_tready <= 1'b0;
            end else if (!wfull && !s_tready) begin
                s_tready <= 1'b1;
            end

            if (acc_m) begin
                mreg       <= meta_data;
                mfull      <= 1'b1;
                meta_ready <= 1'b0;
            end else if (!mfull && !meta_ready) begin
                meta_ready <= 1'b1;
            end
        end
    end
endmodule
